lcd1602_refresh: RTL and testbench
==================================

Name: lcd1602_refresh

Overview:
- Downstream consumer of the 256-bit character buffer and backlight enable produced by the display data-formatting stage.
- Drives the DE2 LCD1602 (HD44780, 8-bit parallel, write-only) directly.
- Runs the power-up init sequence once, then repaints both 16-character lines continuously.
- Each frame is snapshotted at frame start so a line never shows a half-updated time.

Parameters:
- T_POWERUP, 1000000, cycles to wait after reset before the first command (20 ms at 50 MHz).
- T_SETUP, 4, cycles RS/DATA are stable before LCD_EN rises.
- T_EN, 25, cycles LCD_EN is held high.
- T_HOLD, 4, cycles RS/DATA are held after LCD_EN falls.
- T_CMD, 2500, gap cycles after a normal command or data write (50 us).
- T_CLEAR, 100000, gap cycles after the clear command 0x01 (2 ms).
- T_FRAME, 0, extra idle cycles between frames.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- data_in  in  256  character codes; char k (0..31) = data_in[8k+7:8k]. k 0–15 go to line 1, k 16–31 to line 2.
- bl_in  in  1  backlight request.
- LCD_DATA  out  8  HD44780 data bus.
- LCD_RS  out  1  0 = command, 1 = character data.
- LCD_RW  out  1  constant 0 (write only).
- LCD_EN  out  1  enable strobe.
- LCD_ON  out  1  panel power.
- LCD_BLON  out  1  backlight.
- frame_done  out  1  one-cycle pulse after the last char of line 2 completes its gap.

Behaviour:
- Clocking: one clock, CLOCK_50. rst is synchronous and active-high, sampled on the rising edge.
- Reset values: LCD_DATA=0, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_ON=0, LCD_BLON=0, frame_done=0. Main FSM=PWR_WAIT, bus FSM=IDLE, all counters=0.
- Reset mid-operation: aborts any transfer the next cycle, drops LCD_EN to 0, and restarts from PWR_WAIT. Init is re-run in full.
- LCD_ON = 1 from the first cycle after reset deasserts.
- LCD_BLON = bl_in registered, one cycle of latency. It is independent of the FSM and follows bl_in during PWR_WAIT.
- Bus-write sub-FSM, per byte:
  - IDLE: on a write request, latch RS/DATA and go to SETUP.
  - SETUP: T_SETUP cycles, EN=0.
  - EN_HI: T_EN cycles, EN=1.
  - HOLD: T_HOLD cycles, EN=0.
  - GAP: T_CLEAR cycles if the byte was command 0x01, else T_CMD cycles.
  - Then signal done and return to IDLE.
  - Total cycles per byte = T_SETUP+T_EN+T_HOLD+gap.
  - LCD_DATA/LCD_RS must not change from SETUP entry through HOLD exit.
- Main FSM:
  - PWR_WAIT: count T_POWERUP cycles, then go to INIT.
  - INIT: issue commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order (RS=0), using a 3-bit index 0..5. After index 5 completes, go to L1_ADDR. INIT is never revisited without reset.
  - L1_ADDR:
    - On entry, snapshot data_in into a 256-bit frame register.
    - Issue 0x80 (RS=0), then go to L1_CHAR.
  - L1_CHAR: issue snapshot chars 0..15 (RS=1) using a 4-bit index. Wrap 15→0 moves to L2_ADDR.
  - L2_ADDR: issue 0xC0 (RS=0).
  - L2_CHAR: issue chars 16..31. After char 31 completes, pulse frame_done for one cycle and go to FRAME_WAIT.
  - FRAME_WAIT: T_FRAME cycles (0 means skip), then go to L1_ADDR.
- Snapshot: data_in changes during a frame have no effect until the next L1_ADDR entry. Bytes are passed unmodified; no code translation.
- Frame length = 34 writes × (T_SETUP+T_EN+T_HOLD+T_CMD) + T_FRAME cycles.
- Counters must be wide enough for T_POWERUP (20 bits at default). A parameter value of 0 for any gap means 0 cycles in that phase.

Test Plan (override T_POWERUP=20, T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=5, T_CLEAR=12, T_FRAME=0):
- Reset release → LCD_EN stays 0 for exactly 20 cycles. The first EN rise is at cycle 20+2 with LCD_DATA=0x38, RS=0. LCD_ON=1 from cycle 1.
- Init run → six EN pulses with data 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, each EN high 3 cycles. Spacing between EN rises is 12 cycles, except 19 cycles after 0x01.
- data_in = ASCII "2024/05/17 12:30" in line 1 and "Friday" plus spaces in line 2 → bus shows 0x80, then 0x32 0x30 0x32 0x34 …, then 0xC0, 0x46 0x72 …. RS=1 only on chars. Exactly one frame_done pulse per 34 writes.
- Change data_in[7:0] from 0x32 to 0x33 mid-line-1 → the current frame still sends 0x32; the next frame sends 0x33 as its first char.
- Assert rst while LCD_EN=1 in L2_CHAR → LCD_EN=0 on the next cycle and all outputs return to reset values. After release, the full power-up wait and init repeat.
- Toggle bl_in 0→1→0 → LCD_BLON follows one cycle later, with no disturbance to LCD_EN timing.

Source files
------------

// File: rtl/lcd1602_refresh.sv
// ---------------------------------------------------------------------------
// lcd1602_refresh
//
// Drives an HD44780-compatible 16x2 character LCD (8-bit parallel bus,
// write-only). After reset it waits for the panel to power up, runs the
// init command sequence once, then repaints both lines continuously from a
// 32-character buffer. The buffer is copied at the start of every frame so
// that one frame always shows one consistent buffer.
//
// Two cooperating FSMs:
//   - main FSM : PWR_WAIT -> INIT -> {L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR,
//                FRAME_WAIT} (the frame loop repeats)
//   - bus FSM  : writes one byte as IDLE -> SETUP -> EN_HI -> HOLD -> GAP
//
// Ports:
//   CLOCK_50    in   system clock
//   rst         in   synchronous reset, active-high
//   data_in     in   char k (0..31) = data_in[8k+7:8k]; 0..15 line 1,
//                    16..31 line 2
//   bl_in       in   backlight request
//   LCD_DATA    out  HD44780 data bus
//   LCD_RS      out  0 = command, 1 = character data
//   LCD_RW      out  tied to 0 (write only)
//   LCD_EN      out  enable strobe
//   LCD_ON      out  panel power, high from the first cycle out of reset
//   LCD_BLON    out  backlight, bl_in delayed by one cycle
//   frame_done  out  one-cycle pulse after the last char of line 2 has
//                    finished its gap
// ---------------------------------------------------------------------------
module lcd1602_refresh #(
    parameter int unsigned T_POWERUP = 1000000,
    parameter int unsigned T_SETUP   = 4,
    parameter int unsigned T_EN      = 25,
    parameter int unsigned T_HOLD    = 4,
    parameter int unsigned T_CMD     = 2500,
    parameter int unsigned T_CLEAR   = 100000,
    parameter int unsigned T_FRAME   = 0
) (
    input  logic         CLOCK_50,
    input  logic         rst,
    input  logic [255:0] data_in,
    input  logic         bl_in,
    output logic [7:0]   LCD_DATA,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_EN,
    output logic         LCD_ON,
    output logic         LCD_BLON,
    output logic         frame_done
);

    // ------------------------------------------------------------------
    // Counter sizing. Every phase that is actually entered lasts at least
    // one cycle; zero-length phases are skipped by the FSMs instead.
    // The strobe itself cannot be zero cycles, so EN_HI is at least 1.
    // ------------------------------------------------------------------
    localparam int unsigned EN_LEN   = (T_EN == 0) ? 1 : T_EN;

    localparam int unsigned MAIN_MAX = (T_POWERUP > T_FRAME) ? T_POWERUP : T_FRAME;
    localparam int          MW       = (MAIN_MAX > 1) ? $clog2(MAIN_MAX) : 1;

    localparam int unsigned BUS_M0   = (T_SETUP > EN_LEN) ? T_SETUP : EN_LEN;
    localparam int unsigned BUS_M1   = (T_HOLD > BUS_M0) ? T_HOLD : BUS_M0;
    localparam int unsigned BUS_M2   = (T_CMD > BUS_M1) ? T_CMD : BUS_M1;
    localparam int unsigned BUS_MAX  = (T_CLEAR > BUS_M2) ? T_CLEAR : BUS_M2;
    localparam int          BW       = (BUS_MAX > 1) ? $clog2(BUS_MAX) : 1;

    // Terminal counts; only consulted when the matching length is non-zero.
    localparam logic [MW-1:0] PWR_LAST   = MW'(T_POWERUP - 1);
    localparam logic [MW-1:0] FRAME_LAST = MW'(T_FRAME - 1);
    localparam logic [BW-1:0] SETUP_LAST = BW'(T_SETUP - 1);
    localparam logic [BW-1:0] EN_LAST    = BW'(EN_LEN - 1);
    localparam logic [BW-1:0] HOLD_LAST  = BW'(T_HOLD - 1);
    localparam logic [BW-1:0] CMD_LAST   = BW'(T_CMD - 1);
    localparam logic [BW-1:0] CLEAR_LAST = BW'(T_CLEAR - 1);

    typedef enum logic [2:0] {
        M_PWR_WAIT,
        M_INIT,
        M_L1_ADDR,
        M_L1_CHAR,
        M_L2_ADDR,
        M_L2_CHAR,
        M_FRAME_WAIT
    } main_state_e;

    typedef enum logic [2:0] {
        B_IDLE,
        B_SETUP,
        B_EN_HI,
        B_HOLD,
        B_GAP
    } bus_state_e;

    localparam bus_state_e B_FIRST = (T_SETUP != 0) ? B_SETUP : B_EN_HI;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    main_state_e    main_state_q, main_state_d;
    logic [MW-1:0]  main_cnt_q,   main_cnt_d;
    logic [2:0]     init_idx_q,   init_idx_d;
    logic [3:0]     char_idx_q,   char_idx_d;

    bus_state_e     bus_state_q,  bus_state_d,  bus_adv_state;
    logic [BW-1:0]  bus_cnt_q,    bus_cnt_d,    bus_adv_cnt;
    logic           bus_done;

    logic [7:0]     data_q;
    logic           rs_q;
    logic           en_q;
    logic           on_q;
    logic           blon_q;
    logic           frame_done_q, frame_done_d;
    logic [255:0]   frame_q;

    logic           snap;
    logic           issue;
    logic [7:0]     wr_data;
    logic           wr_rs;

    // The gap after a byte depends on whether it was the clear command.
    logic           is_clear;
    logic           gap_zero;
    logic [BW-1:0]  gap_last;

    assign is_clear = !rs_q && (data_q == 8'h01);
    assign gap_zero = is_clear ? (T_CLEAR == 0) : (T_CMD == 0);
    assign gap_last = is_clear ? CLEAR_LAST : CMD_LAST;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_cmd = 8'h38;   // 8-bit bus, 2 lines, 5x8
            3'd3:             init_cmd = 8'h0C;   // display on, no cursor
            3'd4:             init_cmd = 8'h01;   // clear
            default:          init_cmd = 8'h06;   // increment, no shift
        endcase
    endfunction

    function automatic logic is_write(input main_state_e s);
        is_write = (s == M_INIT)    || (s == M_L1_ADDR) || (s == M_L1_CHAR) ||
                   (s == M_L2_ADDR) || (s == M_L2_CHAR);
    endfunction

    // ------------------------------------------------------------------
    // Bus FSM: advance through the phases of the byte in flight. bus_done
    // is high in the final cycle of the final non-empty phase so the next
    // byte can start on the very next edge without an IDLE bubble.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        bus_adv_state = bus_state_q;
        bus_adv_cnt   = bus_cnt_q + 1'b1;
        bus_done      = 1'b0;
        case (bus_state_q)
            B_IDLE: begin
                bus_adv_cnt = '0;
            end
            B_SETUP: begin
                if (bus_cnt_q == SETUP_LAST) begin
                    bus_adv_state = B_EN_HI;
                    bus_adv_cnt   = '0;
                end
            end
            B_EN_HI: begin
                if (bus_cnt_q == EN_LAST) begin
                    bus_adv_cnt = '0;
                    if (T_HOLD != 0) begin
                        bus_adv_state = B_HOLD;
                    end else if (!gap_zero) begin
                        bus_adv_state = B_GAP;
                    end else begin
                        bus_adv_state = B_IDLE;
                        bus_done      = 1'b1;
                    end
                end
            end
            B_HOLD: begin
                if (bus_cnt_q == HOLD_LAST) begin
                    bus_adv_cnt = '0;
                    if (!gap_zero) begin
                        bus_adv_state = B_GAP;
                    end else begin
                        bus_adv_state = B_IDLE;
                        bus_done      = 1'b1;
                    end
                end
            end
            B_GAP: begin
                if (bus_cnt_q == gap_last) begin
                    bus_adv_state = B_IDLE;
                    bus_adv_cnt   = '0;
                    bus_done      = 1'b1;
                end
            end
            default: begin
                bus_adv_state = B_IDLE;
                bus_adv_cnt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Main FSM next state.
    // ------------------------------------------------------------------
    always_comb begin
        main_state_d = main_state_q;
        main_cnt_d   = main_cnt_q;
        init_idx_d   = init_idx_q;
        char_idx_d   = char_idx_q;
        frame_done_d = 1'b0;
        snap         = 1'b0;
        case (main_state_q)
            M_PWR_WAIT: begin
                if (T_POWERUP == 0 || main_cnt_q == PWR_LAST) begin
                    main_state_d = M_INIT;
                    main_cnt_d   = '0;
                    init_idx_d   = '0;
                end else begin
                    main_cnt_d = main_cnt_q + 1'b1;
                end
            end
            M_INIT: begin
                if (bus_done) begin
                    if (init_idx_q == 3'd5) begin
                        main_state_d = M_L1_ADDR;
                        snap         = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                    end
                end
            end
            M_L1_ADDR: begin
                if (bus_done) begin
                    main_state_d = M_L1_CHAR;
                    char_idx_d   = '0;
                end
            end
            M_L1_CHAR: begin
                if (bus_done) begin
                    char_idx_d = char_idx_q + 4'd1;
                    if (char_idx_q == 4'd15) begin
                        main_state_d = M_L2_ADDR;
                    end
                end
            end
            M_L2_ADDR: begin
                if (bus_done) begin
                    main_state_d = M_L2_CHAR;
                    char_idx_d   = '0;
                end
            end
            M_L2_CHAR: begin
                if (bus_done) begin
                    char_idx_d = char_idx_q + 4'd1;
                    if (char_idx_q == 4'd15) begin
                        frame_done_d = 1'b1;
                        if (T_FRAME == 0) begin
                            main_state_d = M_L1_ADDR;
                            snap         = 1'b1;
                        end else begin
                            main_state_d = M_FRAME_WAIT;
                            main_cnt_d   = '0;
                        end
                    end
                end
            end
            M_FRAME_WAIT: begin
                if (main_cnt_q == FRAME_LAST) begin
                    main_state_d = M_L1_ADDR;
                    main_cnt_d   = '0;
                    snap         = 1'b1;
                end else begin
                    main_cnt_d = main_cnt_q + 1'b1;
                end
            end
            default: begin
                main_state_d = M_PWR_WAIT;
                main_cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write request: a byte is launched whenever the main FSM is (or is
    // about to be) in a write state and the bus is free -- either it just
    // finished the previous byte, or the main FSM is arriving from a wait
    // state. The byte is chosen from the *next* main state so it latches
    // on the same edge the main FSM advances.
    // ------------------------------------------------------------------
    always_comb begin
        issue   = is_write(main_state_d) && (bus_done || !is_write(main_state_q));
        wr_data = 8'h00;
        wr_rs   = 1'b0;
        case (main_state_d)
            M_INIT:    wr_data = init_cmd(init_idx_d);
            M_L1_ADDR: wr_data = 8'h80;
            M_L1_CHAR: begin
                wr_data = frame_q[{1'b0, char_idx_d, 3'b000} +: 8];
                wr_rs   = 1'b1;
            end
            M_L2_ADDR: wr_data = 8'hC0;
            M_L2_CHAR: begin
                wr_data = frame_q[{1'b1, char_idx_d, 3'b000} +: 8];
                wr_rs   = 1'b1;
            end
            default: begin
                wr_data = 8'h00;
                wr_rs   = 1'b0;
            end
        endcase

        bus_state_d = issue ? B_FIRST : bus_adv_state;
        bus_cnt_d   = issue ? '0      : bus_adv_cnt;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            main_state_q <= M_PWR_WAIT;
            main_cnt_q   <= '0;
            init_idx_q   <= '0;
            char_idx_q   <= '0;
            bus_state_q  <= B_IDLE;
            bus_cnt_q    <= '0;
            data_q       <= '0;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            on_q         <= 1'b0;
            blon_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            main_state_q <= main_state_d;
            main_cnt_q   <= main_cnt_d;
            init_idx_q   <= init_idx_d;
            char_idx_q   <= char_idx_d;
            bus_state_q  <= bus_state_d;
            bus_cnt_q    <= bus_cnt_d;
            // RS/DATA only move when a new byte is launched, so they stay
            // put from SETUP entry through HOLD exit.
            if (issue) begin
                data_q <= wr_data;
                rs_q   <= wr_rs;
            end
            // Registered from next state so the strobe is glitch-free.
            en_q         <= (bus_state_d == B_EN_HI);
            on_q         <= 1'b1;
            blon_q       <= bl_in;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the frame copy has no reset; it is always reloaded on entry to
    // L1_ADDR before any character is read from it.
    always_ff @(posedge CLOCK_50) begin
        if (snap) begin
            frame_q <= data_in;
        end
    end

    assign LCD_DATA   = data_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_q;
    assign LCD_ON     = on_q;
    assign LCD_BLON   = blon_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd1602_refresh.sv
// ---------------------------------------------------------------------------
// tb_lcd1602_refresh
//
// Directed bench for lcd1602_refresh with shortened timing. Expected bus
// writes (RS, byte, spacing from the previous EN rise) are queued when the
// stimulus is set up and popped by a monitor on every LCD_EN rising edge.
// ---------------------------------------------------------------------------
module tb_lcd1602_refresh;

    localparam int unsigned P_POWERUP = 20;
    localparam int unsigned P_SETUP   = 2;
    localparam int unsigned P_EN      = 3;
    localparam int unsigned P_HOLD    = 2;
    localparam int unsigned P_CMD     = 5;
    localparam int unsigned P_CLEAR   = 12;
    localparam int unsigned P_FRAME   = 0;

    localparam int SPACING     = P_SETUP + P_EN + P_HOLD + P_CMD;    // 12
    localparam int SPACING_CLR = P_SETUP + P_EN + P_HOLD + P_CLEAR;  // 19
    localparam int FIRST_EN    = P_POWERUP + P_SETUP;                // 22
    localparam int FD_DELAY    = P_EN + P_HOLD + P_CMD;              // 10
    localparam int BOUND       = 3000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] data_in;
    logic         bl_in = 1'b0;
    logic [7:0]   lcd_data;
    logic         lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, frame_done;

    lcd1602_refresh #(
        .T_POWERUP (P_POWERUP),
        .T_SETUP   (P_SETUP),
        .T_EN      (P_EN),
        .T_HOLD    (P_HOLD),
        .T_CMD     (P_CMD),
        .T_CLEAR   (P_CLEAR),
        .T_FRAME   (P_FRAME)
    ) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .data_in    (data_in),
        .bl_in      (bl_in),
        .LCD_DATA   (lcd_data),
        .LCD_RS     (lcd_rs),
        .LCD_RW     (lcd_rw),
        .LCD_EN     (lcd_en),
        .LCD_ON     (lcd_on),
        .LCD_BLON   (lcd_blon),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic [7:0] gap;    // expected cycles since previous EN rise, 0 = unchecked
        logic       last;   // final char of line 2
    } wr_t;

    wr_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  pops     = 0;
    int  fd_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d, input int gap, input logic last);
        wr_t w;
        w.rs   = rs;
        w.data = d;
        w.gap  = 8'(gap);
        w.last = last;
        sb_q.push_back(w);
    endtask

    task automatic push_init();
        logic [7:0] cmds [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        logic [7:0] prev = 8'h00;
        for (int i = 0; i < 6; i++) begin
            push(1'b0, cmds[i], (i == 0) ? 0 : ((prev == 8'h01) ? SPACING_CLR : SPACING), 1'b0);
            prev = cmds[i];
        end
    endtask

    // The address command following 0x06 or the previous frame's last char
    // both follow a normal gap.
    task automatic push_frame(input logic [255:0] d);
        push(1'b0, 8'h80, SPACING, 1'b0);
        for (int k = 0; k < 16; k++) push(1'b1, d[8*k +: 8], SPACING, 1'b0);
        push(1'b0, 8'hC0, SPACING, 1'b0);
        for (int k = 16; k < 32; k++) push(1'b1, d[8*k +: 8], SPACING, k == 31);
    endtask

    function automatic logic [255:0] make_frame(input string l1, input string l2);
        logic [255:0] f = {32{8'h20}};
        for (int k = 0; k < 16; k++) begin
            if (k < l1.len()) f[8*k +: 8] = l1[k];
            if (k < l2.len()) f[8*(k+16) +: 8] = l2[k];
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Bus monitor: samples on the falling edge.
    // ------------------------------------------------------------------
    logic       en_prev = 1'b0;
    logic       fd_prev = 1'b0;
    logic       last_is_end = 1'b0;
    int         last_rise = 0;
    int         en_width = 0;
    logic [8:0] rise_bus = '0;
    wr_t        exp_w;

    always @(negedge clk) begin
        if (rst) begin
            en_prev  = 1'b0;
            fd_prev  = 1'b0;
            en_width = 0;
        end else begin
            if (lcd_en && !en_prev) begin
                check("sb_not_empty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    exp_w = sb_q.pop_front();
                    pops++;
                    check("wr_rs", lcd_rs, exp_w.rs);
                    check("wr_data", lcd_data, exp_w.data);
                    if (exp_w.gap != 0) check("wr_spacing", cyc - last_rise, exp_w.gap);
                    last_is_end = exp_w.last;
                end
                last_rise = cyc;
                rise_bus  = {lcd_rs, lcd_data};
                en_width  = 1;
            end else if (lcd_en) begin
                en_width++;
                check("bus_stable_en", {lcd_rs, lcd_data}, rise_bus);
            end else if (en_prev) begin
                check("en_width", en_width, P_EN);
                check("bus_stable_hold", {lcd_rs, lcd_data}, rise_bus);
            end
            if (frame_done) begin
                fd_count++;
                check("fd_width", fd_prev, 0);
                check("fd_timing", cyc - last_rise, FD_DELAY);
                check("fd_after_last_char", last_is_end, 1);
            end
            check("rw_low", lcd_rw, 0);
            en_prev = lcd_en;
            fd_prev = frame_done;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, lcd_data, 0);
        check({tag, "_rs"},   lcd_rs,   0);
        check({tag, "_rw"},   lcd_rw,   0);
        check({tag, "_en"},   lcd_en,   0);
        check({tag, "_on"},   lcd_on,   0);
        check({tag, "_blon"}, lcd_blon, 0);
        check({tag, "_fd"},   frame_done, 0);
    endtask

    initial begin
        int n;
        logic [255:0] frame_a;

        frame_a = make_frame("2024/05/17 12:30", "Friday");
        data_in = frame_a;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        push_init();
        push_frame(frame_a);

        // Release reset and measure power-up wait
        rst = 1'b0;
        n = 0;
        while (n < 100 && !lcd_en) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check("lcd_on_cycle1", lcd_on, 1);
        end
        check("first_en_cycle", n, FIRST_EN);
        check("first_en_data", lcd_data, 8'h38);

        // Backlight toggle during init; EN spacing is checked by the monitor
        @(posedge clk);
        #1;
        bl_in = 1'b1;
        check("blon_pre_edge", lcd_blon, 0);
        @(posedge clk);
        #1;
        check("blon_rise", lcd_blon, 1);
        bl_in = 1'b0;
        @(posedge clk);
        #1;
        check("blon_fall", lcd_blon, 0);

        // After the line-1 address has gone out, the frame is already
        // snapshotted: change char 0, which must only show next frame.
        n = 0;
        while (n < BOUND && pops < 7) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_l1_addr", 32'(pops >= 7), 1);
        data_in[7:0] = 8'h33;
        push_frame(data_in);

        n = 0;
        while (n < BOUND && fd_count < 1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("fd_count_frame1", fd_count, 1);

        // Reset while EN is high on the 3rd char of line 2 in frame 2
        n = 0;
        while (n < BOUND && !(pops >= 61 && lcd_en)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("en_in_l2_char", lcd_en, 1);
        check("rs_in_l2_char", lcd_rs, 1);
        check("fd_count_before_reset", fd_count, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("en_drop_after_reset", lcd_en, 0);
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midreset_hold");

        sb_q.delete();
        fd_count = 0;
        push_init();
        push_frame(data_in);

        // Release with backlight requested: it must follow during PWR_WAIT
        rst   = 1'b0;
        bl_in = 1'b1;
        n = 0;
        while (n < 100 && !lcd_en) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check("re_lcd_on_cycle1", lcd_on, 1);
                check("blon_pwr_wait", lcd_blon, 1);
            end
            if (n == 5) bl_in = 1'b0;
            if (n == 6) check("blon_pwr_wait_off", lcd_blon, 0);
        end
        check("re_first_en_cycle", n, FIRST_EN);

        n = 0;
        while (n < BOUND && fd_count < 1) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("fd_count_after_reinit", fd_count, 1);
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
